// File: rtl/branch_resolution_unit_pkg.sv
// Shared definitions for the branch resolution unit: branch classes,
// FSM states and the per-instruction prediction metadata record.
package branch_resolution_unit_pkg;

  localparam logic [1:0] BRANCH_OP_NONE = 2'b00;
  localparam logic [1:0] BRANCH_OP_COND = 2'b01;
  localparam logic [1:0] BRANCH_OP_JAL  = 2'b10;
  localparam logic [1:0] BRANCH_OP_JALR = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } bru_state_t;

  typedef struct packed {
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_meta_t;

  localparam pred_meta_t PRED_META_ZERO = '{pred_taken: 1'b0, pred_target: 32'h0};

endpackage

// File: rtl/bru_meta_stage.sv
// One pipeline register carrying a prediction record alongside its
// instruction. Reset beats clear, and clear beats load, so a flush always
// empties the stage even while it is stalled.
module bru_meta_stage
  import branch_resolution_unit_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       clear_i,
  input  pred_meta_t meta_i,
  output pred_meta_t meta_o
);

  pred_meta_t meta_q;

  // Stage register: reset, then flush, then advance when not stalled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= PRED_META_ZERO;
    end else if (clear_i) begin
      meta_q <= PRED_META_ZERO;
    end else if (load_i) begin
      meta_q <= meta_i;
    end
  end

  assign meta_o = meta_q;

endmodule

// File: rtl/branch_resolution_unit.sv
// Execute-stage branch resolution. Carries the fetch-stage prediction down
// to execute, compares it with the real outcome, raises the misprediction,
// flushes the younger stages and holds the corrected fetch PC until fetch
// is able to take it.
// Optional feature macro: BRU_PERF_CNT_EN adds branch and misprediction
// counters (branch_cnt_o, mispredict_cnt_o).
module branch_resolution_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_fi_i,
  input  logic        stall_de_i,
  input  logic        stall_ex_i,
  input  logic        pc_src_pred_fi_i,
  input  logic [31:0] pred_pc_target_fi_i,
  input  logic [1:0]  branch_op_ex_i,
  input  logic        branch_taken_ex_i,
  input  logic [31:0] pc_target_ex_i,
  input  logic [31:0] pc_plus4_ex_i,
  output logic        pc_src_res_ex_o,
  output logic        target_match_ex_o,
  output logic        mispredict_ex_o,
  output logic        flush_de_o,
  output logic        flush_ex_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
`endif
);

  import branch_resolution_unit_pkg::*;

  pred_meta_t  metaFetch;
  pred_meta_t  metaDecode;
  pred_meta_t  metaExecute;

  bru_state_t  state_q;
  bru_state_t  state_d;
  logic [31:0] redirect_q;
  logic [31:0] redirect_d;

  logic        mismatchRaw;
  logic [31:0] correctPc;

  assign metaFetch.pred_taken  = pc_src_pred_fi_i;
  assign metaFetch.pred_target = pred_pc_target_fi_i;

  bru_meta_stage u_meta_fd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (!stall_de_i),
    .clear_i (flush_de_o),
    .meta_i  (metaFetch),
    .meta_o  (metaDecode)
  );

  bru_meta_stage u_meta_de (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (!stall_ex_i),
    .clear_i (flush_ex_o),
    .meta_i  (metaDecode),
    .meta_o  (metaExecute)
  );

  // Actual taken outcome: jumps always redirect, conditionals follow the compare.
  always_comb begin
    pc_src_res_ex_o = 1'b0;
    unique case (branch_op_ex_i)
      BRANCH_OP_NONE: pc_src_res_ex_o = 1'b0;
      BRANCH_OP_COND: pc_src_res_ex_o = branch_taken_ex_i;
      BRANCH_OP_JAL:  pc_src_res_ex_o = 1'b1;
      BRANCH_OP_JALR: pc_src_res_ex_o = 1'b1;
      default:        pc_src_res_ex_o = 1'b0;
    endcase
  end

  assign target_match_ex_o = (metaExecute.pred_target == pc_target_ex_i);

  // A taken prediction on a non-branch (BTB alias) also counts as a mismatch.
  assign mismatchRaw = (metaExecute.pred_taken != pc_src_res_ex_o) ||
                       (metaExecute.pred_taken && pc_src_res_ex_o && !target_match_ex_o);

  assign mispredict_ex_o = mismatchRaw && !stall_ex_i && (state_q == IDLE) && !reset_i;

  assign correctPc = pc_src_res_ex_o ? pc_target_ex_i : pc_plus4_ex_i;

  // Redirect FSM register: HOLD keeps the corrected PC alive across fetch stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      redirect_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  // Redirect FSM next state and flush/redirect outputs; reset silences outputs.
  always_comb begin
    state_d          = state_q;
    redirect_d       = redirect_q;
    flush_de_o       = 1'b0;
    flush_ex_o       = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (mispredict_ex_o) begin
          flush_de_o       = 1'b1;
          flush_ex_o       = 1'b1;
          redirect_valid_o = 1'b1;
          redirect_pc_o    = correctPc;
          redirect_d       = correctPc;
          if (stall_fi_i) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        flush_de_o       = 1'b1;
        flush_ex_o       = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = redirect_q;
        if (!stall_fi_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset_i) begin
      flush_de_o       = 1'b0;
      flush_ex_o       = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = 32'h0;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branchCnt_q;
  logic [31:0] mispredictCnt_q;

  // Performance counters: branches leaving E outside HOLD, and mispredictions.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      branchCnt_q     <= 32'h0;
      mispredictCnt_q <= 32'h0;
    end else begin
      if (!stall_ex_i && (branch_op_ex_i != BRANCH_OP_NONE) && (state_q != HOLD)) begin
        branchCnt_q <= branchCnt_q + 32'd1;
      end
      if (mispredict_ex_o) begin
        mispredictCnt_q <= mispredictCnt_q + 32'd1;
      end
    end
  end

  assign branch_cnt_o     = branchCnt_q;
  assign mispredict_cnt_o = mispredictCnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: a table of single-branch
// vectors plus hand-written HOLD, execute-stall and reset-in-HOLD sequences.
module tb_branch_resolution_unit;

  typedef struct {
    logic        res;
    logic        match;
    logic        misp;
    logic        fde;
    logic        fex;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] pc4;
    logic        predTaken;
    logic [31:0] predTarget;
    exp_t        e;
  } vec_t;

  logic        clk_i;
  logic        reset_i;
  logic        stall_fi_i;
  logic        stall_de_i;
  logic        stall_ex_i;
  logic        pc_src_pred_fi_i;
  logic [31:0] pred_pc_target_fi_i;
  logic [1:0]  branch_op_ex_i;
  logic        branch_taken_ex_i;
  logic [31:0] pc_target_ex_i;
  logic [31:0] pc_plus4_ex_i;
  logic        pc_src_res_ex_o;
  logic        target_match_ex_o;
  logic        mispredict_ex_o;
  logic        flush_de_o;
  logic        flush_ex_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  vec_t vecs[10];

  branch_resolution_unit dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .stall_fi_i          (stall_fi_i),
    .stall_de_i          (stall_de_i),
    .stall_ex_i          (stall_ex_i),
    .pc_src_pred_fi_i    (pc_src_pred_fi_i),
    .pred_pc_target_fi_i (pred_pc_target_fi_i),
    .branch_op_ex_i      (branch_op_ex_i),
    .branch_taken_ex_i   (branch_taken_ex_i),
    .pc_target_ex_i      (pc_target_ex_i),
    .pc_plus4_ex_i       (pc_plus4_ex_i),
    .pc_src_res_ex_o     (pc_src_res_ex_o),
    .target_match_ex_o   (target_match_ex_o),
    .mispredict_ex_o     (mispredict_ex_o),
    .flush_de_o          (flush_de_o),
    .flush_ex_o          (flush_ex_o),
    .redirect_valid_o    (redirect_valid_o),
    .redirect_pc_o       (redirect_pc_o)
`ifdef BRU_PERF_CNT_EN
    ,
    .branch_cnt_o        (branch_cnt_o),
    .mispredict_cnt_o    (mispredict_cnt_o)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic exp_t mkExp(input logic res, input logic match, input logic misp,
                                 input logic flush, input logic [31:0] rpc);
    exp_t e;
    e.res   = res;
    e.match = match;
    e.misp  = misp;
    e.fde   = flush;
    e.fex   = flush;
    e.rv    = flush;
    e.rpc   = rpc;
    return e;
  endfunction

  function automatic vec_t mkVec(input logic [1:0] op, input logic taken,
                                 input logic [31:0] tgt, input logic [31:0] pc4,
                                 input logic pT, input logic [31:0] pTgt,
                                 input logic res, input logic match, input logic misp,
                                 input logic [31:0] rpc);
    vec_t v;
    v.op         = op;
    v.taken      = taken;
    v.tgt        = tgt;
    v.pc4        = pc4;
    v.predTaken  = pT;
    v.predTarget = pTgt;
    v.e          = mkExp(res, match, misp, misp, rpc);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setFetch(input logic taken, input logic [31:0] target);
    pc_src_pred_fi_i    = taken;
    pred_pc_target_fi_i = target;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic taken,
                               input logic [31:0] tgt, input logic [31:0] pc4,
                               input logic sfi, input logic sde, input logic sex,
                               input exp_t e);
    branch_op_ex_i    = op;
    branch_taken_ex_i = taken;
    pc_target_ex_i    = tgt;
    pc_plus4_ex_i     = pc4;
    stall_fi_i        = sfi;
    stall_de_i        = sde;
    stall_ex_i        = sex;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(negedge clk_i);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
    end else begin
      e = expQ.pop_front();
      cmp({tag, ".pc_src_res"},     {31'h0, pc_src_res_ex_o},   {31'h0, e.res});
      cmp({tag, ".target_match"},   {31'h0, target_match_ex_o}, {31'h0, e.match});
      cmp({tag, ".mispredict"},     {31'h0, mispredict_ex_o},   {31'h0, e.misp});
      cmp({tag, ".flush_de"},       {31'h0, flush_de_o},        {31'h0, e.fde});
      cmp({tag, ".flush_ex"},       {31'h0, flush_ex_o},        {31'h0, e.fex});
      cmp({tag, ".redirect_valid"}, {31'h0, redirect_valid_o},  {31'h0, e.rv});
      cmp({tag, ".redirect_pc"},    redirect_pc_o,              e.rpc);
    end
    @(posedge clk_i);
    #1;
  endtask

  // Two idle cycles that carry a prediction from fetch into execute.
  task automatic prime(input logic taken, input logic [31:0] target, input string tag);
    setFetch(taken, target);
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    checkOutput({tag, ".primeA"});
    setFetch(1'b0, 32'h0);
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    checkOutput({tag, ".primeB"});
  endtask

  // Main sequence: reset, table vectors, then multi-cycle corner cases.
  initial begin
    //                op     tk    tgt            pc4           pT    pTgt           res   match misp  rpc
    vecs[0] = mkVec(2'b01, 1'b1, 32'h100,      32'h104,      1'b1, 32'h100,      1'b1, 1'b1, 1'b0, 32'h0);
    vecs[1] = mkVec(2'b01, 1'b1, 32'h200,      32'h8,        1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h200);
    vecs[2] = mkVec(2'b01, 1'b0, 32'h300,      32'h1C,       1'b1, 32'h300,      1'b0, 1'b1, 1'b1, 32'h1C);
    vecs[3] = mkVec(2'b01, 1'b0, 32'h40,       32'h24,       1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
    vecs[4] = mkVec(2'b10, 1'b0, 32'h500,      32'h30,       1'b1, 32'h500,      1'b1, 1'b1, 1'b0, 32'h0);
    vecs[5] = mkVec(2'b10, 1'b0, 32'h504,      32'h34,       1'b1, 32'h500,      1'b1, 1'b0, 1'b1, 32'h504);
    vecs[6] = mkVec(2'b11, 1'b0, 32'h600,      32'h38,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h600);
    vecs[7] = mkVec(2'b00, 1'b0, 32'h800,      32'h44,       1'b1, 32'h800,      1'b0, 1'b1, 1'b1, 32'h44);
    vecs[8] = mkVec(2'b00, 1'b1, 32'h10,       32'h48,       1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
    vecs[9] = mkVec(2'b11, 1'b0, 32'h7FFFFFFC, 32'h4C,       1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1, 32'h7FFFFFFC);

    reset_i = 1'b1;
    setFetch(1'b0, 32'h0);
    branch_op_ex_i    = 2'b00;
    branch_taken_ex_i = 1'b0;
    pc_target_ex_i    = 32'h0;
    pc_plus4_ex_i     = 32'h0;
    stall_fi_i        = 1'b0;
    stall_de_i        = 1'b0;
    stall_ex_i        = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    checkOutput("reset");
    reset_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      prime(vecs[i].predTaken, vecs[i].predTarget, $sformatf("vec%0d", i));
      applyStimulus(vecs[i].op, vecs[i].taken, vecs[i].tgt, vecs[i].pc4,
                    1'b0, 1'b0, 1'b0, vecs[i].e);
      checkOutput($sformatf("vec%0d", i));
    end

    // BTB alias with fetch stalled three cycles: redirect held four cycles.
    prime(1'b1, 32'h900, "hold");
    applyStimulus(2'b00, 1'b0, 32'h900, 32'h44, 1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b1, 1'b1, 32'h44));
    checkOutput("hold.c1");
    applyStimulus(2'b10, 1'b0, 32'h999, 32'h0, 1'b1, 1'b0, 1'b0, mkExp(1'b1, 1'b0, 1'b0, 1'b1, 32'h44));
    checkOutput("hold.c2");
    applyStimulus(2'b10, 1'b0, 32'h999, 32'h0, 1'b1, 1'b0, 1'b0, mkExp(1'b1, 1'b0, 1'b0, 1'b1, 32'h44));
    checkOutput("hold.c3");
    applyStimulus(2'b10, 1'b0, 32'h999, 32'h0, 1'b0, 1'b0, 1'b0, mkExp(1'b1, 1'b0, 1'b0, 1'b1, 32'h44));
    checkOutput("hold.c4");
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    checkOutput("hold.idle");

    // JALR with wrong target, held in execute for two cycles.
    prime(1'b1, 32'h300, "exstall");
    applyStimulus(2'b11, 1'b0, 32'h304, 32'h60, 1'b0, 1'b1, 1'b1, mkExp(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    checkOutput("exstall.c1");
    applyStimulus(2'b11, 1'b0, 32'h304, 32'h60, 1'b0, 1'b1, 1'b1, mkExp(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    checkOutput("exstall.c2");
    applyStimulus(2'b11, 1'b0, 32'h304, 32'h60, 1'b0, 1'b0, 1'b0, mkExp(1'b1, 1'b0, 1'b1, 1'b1, 32'h304));
    checkOutput("exstall.c3");
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    checkOutput("exstall.idle");

    // Reset while holding a redirect: redirect dropped, metadata cleared.
    prime(1'b0, 32'h0, "rsthold");
    applyStimulus(2'b01, 1'b1, 32'h700, 32'h10, 1'b1, 1'b0, 1'b0, mkExp(1'b1, 1'b0, 1'b1, 1'b1, 32'h700));
    checkOutput("rsthold.c1");
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b1, 32'h700));
    checkOutput("rsthold.hold");
    reset_i = 1'b1;
    setFetch(1'b1, 32'hABC);
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    checkOutput("rsthold.inreset");
    reset_i = 1'b0;
    setFetch(1'b0, 32'h0);
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
`ifdef BRU_PERF_CNT_EN
    @(negedge clk_i);
    cmp("rsthold.branch_cnt", branch_cnt_o, 32'h0);
    cmp("rsthold.mispredict_cnt", mispredict_cnt_o, 32'h0);
`endif
    checkOutput("rsthold.after1");
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    checkOutput("rsthold.after2");

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, 0 required", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
